control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk (input, 1, rising-edge clock), then clr (input, 1, asynchronous active-low reset).
REQ-002 start  input  1  pulse that begins execution; sampled only in IDLE.
REQ-003 ir  input  [31:0]  current IR contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-004 mem_ready  input  1  memory read data valid this cycle.
REQ-005 bus_sel  output  [24:0]  one-hot bus source select to the datapath encoder; bit map: R0-R15=0-15, HI=16, LO=17, Zhigh=18, Zlow=19, PC=20, IR=21, MDR=22, MAR=23, Y=24.
REQ-006 in_en  output  [24:0]  register load enables, same bit map as bus_sel.
REQ-007 alu_op  output  [3:0]  ALU operation; 0 = pass/idle.
REQ-008 inc_pc  output  1  ALU computes PC+1 into Z.
REQ-009 read  output  1  memory read / MDR mux selects Mdatain.
REQ-010 busy, halted, illegal  output  1 each  status flags.

Function
REQ-011 States SHALL be: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED, ERROR.
REQ-012 IDLE: start=1 -> T0 next edge; start while not IDLE SHALL be ignored.
REQ-013 T0: bus_sel[PC], in_en[MAR], inc_pc=1, in_en[Zlow]; -> T1.
REQ-014 T1: bus_sel[Zlow], in_en[PC] on first T1 cycle only; read=1 every T1 cycle; in_en[MDR]=mem_ready; mem_ready=1 -> T2, else stay.
REQ-015 T1 wait counter (4 bits) SHALL clear on T1 entry, increment each T1 cycle with mem_ready=0; at 15 with mem_ready=0 -> ERROR.
REQ-016 T2: bus_sel[MDR], in_en[IR]; -> T3.
REQ-017 T3 decodes ir: nop 11010 -> T0 (no enables); halt 11011 -> HALTED; undefined opcode -> ERROR; ALU/mul/div: bus_sel[Rb], in_en[Y] -> T4.
REQ-018 ALU opcodes -> alu_op: add 00011->1, sub 00100->2, and 00101->3, or 00110->4, shr 00111->5, shl 01000->6, ror 01001->7, rol 01010->8, mul 01111->9, div 10000->10.
REQ-019 T4: bus_sel[Rc], alu_op per REQ-018, in_en[Zlow] and in_en[Zhigh]; -> T5.
REQ-020 T5: bus_sel[Zlow]; ALU ops: in_en[Ra] -> T0; mul/div: in_en[LO] -> T6.
REQ-021 T6: bus_sel[Zhigh], in_en[HI]; -> T0.
REQ-022 Ra=0 SHALL be a legal destination (R0 written).
REQ-023 bus_sel SHALL be exactly one-hot in T0-T6 and all-zero in IDLE, HALTED, ERROR; outputs are a decode of state register and ir only.
REQ-024 Latency: ALU op with mem_ready=1 in first T1 = 6 cycles T0->T0; mul/div = 7; nop = 4; each T1 wait cycle adds 1.
REQ-025 busy=1 in T0-T6; halted=1 in HALTED; illegal=1 in ERROR.
REQ-026 HALTED and ERROR SHALL be absorbing; exit only via clr.

Reset
REQ-027 clr=0 SHALL asynchronously force IDLE, wait counter 0, and every output 0, including mid-instruction and during T1 wait.
REQ-028 After clr deassert, the first start sampled SHALL enter T0 on the next edge.

Structure
REQ-029 Package cpu_ctrl_pkg SHALL hold the state enumeration, opcode constants, alu_op codes and the 25-bit bus index constants (shared with datapath).
REQ-030 One sub-module instr_decode (combinational: ir -> opcode class, alu_op, Ra/Rb/Rc one-hot) SHALL be used.

Verification
REQ-031 clr low, start=1, mem_ready=1, ir=add R1,R2,R3 (0x18918000) -> T0..T5 then T0; T3 bus_sel=bit2, T4 bus_sel=bit3 alu_op=1, T5 in_en=bit1.
REQ-032 ir=mul R0,R4,R5 (0x78228000) -> T5 in_en[LO], T6 bus_sel[Zhigh] in_en[HI], 7 cycles, alu_op=9 in T4.
REQ-033 mem_ready low 3 cycles then high -> T1 held 4 cycles, in_en[PC] only on first, in_en[MDR] only on fourth; mem_ready never high -> ERROR after 16 T1 cycles, illegal=1.
REQ-034 ir opcode 11111 -> ERROR at T3+1, illegal=1, bus_sel=0; opcode 11011 -> HALTED, halted=1, start ignored.
REQ-035 clr pulsed low mid-T4 -> immediately IDLE, all outputs 0 before next edge; start afterwards -> T0.
REQ-036 Every cycle assertion: $onehot0(bus_sel); start during busy has no effect on state.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, opcode, ALU and bus-index definitions for the CPU control path
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALTED,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;

    localparam int BUS_W     = 25;
    localparam int BUS_HI    = 16;
    localparam int BUS_LO    = 17;
    localparam int BUS_ZHIGH = 18;
    localparam int BUS_ZLOW  = 19;
    localparam int BUS_PC    = 20;
    localparam int BUS_IR    = 21;
    localparam int BUS_MDR   = 22;
    localparam int BUS_MAR   = 23;
    localparam int BUS_Y     = 24;

    function automatic logic [BUS_W-1:0] bus_bit(input int idx);
        return BUS_W'(1) << idx;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational IR decode into opcode class, ALU code and one-hot register selects
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output op_class_t   op_class_o,
    output logic [3:0]  alu_op_o,
    output logic [15:0] ra_oh_o,
    output logic [15:0] rb_oh_o,
    output logic [15:0] rc_oh_o
);

    // Low IR bits carry immediates the sequencer never looks at.
    logic unused_ir_low;
    assign unused_ir_low = ^ir_i[14:0];

    assign ra_oh_o = 16'(1) << ir_i[26:23];
    assign rb_oh_o = 16'(1) << ir_i[22:19];
    assign rc_oh_o = 16'(1) << ir_i[18:15];

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        alu_op_o   = ALU_PASS;
        case (ir_i[31:27])
            OP_ADD:  begin op_class_o = CLS_ALU;    alu_op_o = ALU_ADD; end
            OP_SUB:  begin op_class_o = CLS_ALU;    alu_op_o = ALU_SUB; end
            OP_AND:  begin op_class_o = CLS_ALU;    alu_op_o = ALU_AND; end
            OP_OR:   begin op_class_o = CLS_ALU;    alu_op_o = ALU_OR;  end
            OP_SHR:  begin op_class_o = CLS_ALU;    alu_op_o = ALU_SHR; end
            OP_SHL:  begin op_class_o = CLS_ALU;    alu_op_o = ALU_SHL; end
            OP_ROR:  begin op_class_o = CLS_ALU;    alu_op_o = ALU_ROR; end
            OP_ROL:  begin op_class_o = CLS_ALU;    alu_op_o = ALU_ROL; end
            OP_MUL:  begin op_class_o = CLS_MULDIV; alu_op_o = ALU_MUL; end
            OP_DIV:  begin op_class_o = CLS_MULDIV; alu_op_o = ALU_DIV; end
            OP_NOP:  op_class_o = CLS_NOP;
            OP_HALT: op_class_o = CLS_HALT;
            default: op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/decode/execute control FSM driving bus selects and load enables
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [24:0] bus_sel,
    output logic [24:0] in_en,
    output logic [3:0]  alu_op,
    output logic        inc_pc,
    output logic        read,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;

    op_class_t   dec_class;
    logic [3:0]  dec_alu_op;
    logic [15:0] ra_oh, rb_oh, rc_oh;

    instr_decode u_instr_decode (
        .ir_i       (ir),
        .op_class_o (dec_class),
        .alu_op_o   (dec_alu_op),
        .ra_oh_o    (ra_oh),
        .rb_oh_o    (rb_oh),
        .rc_oh_o    (rc_oh)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        bus_sel = '0;
        in_en   = '0;
        alu_op  = ALU_PASS;
        inc_pc  = 1'b0;
        read    = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_T0;
            end
            S_T0: begin
                busy    = 1'b1;
                bus_sel = bus_bit(BUS_PC);
                in_en   = bus_bit(BUS_MAR) | bus_bit(BUS_ZLOW);
                inc_pc  = 1'b1;
                wait_d  = 4'd0;
                state_d = S_T1;
            end
            S_T1: begin
                busy    = 1'b1;
                read    = 1'b1;
                bus_sel = bus_bit(BUS_ZLOW);
                // A zero wait count marks the first T1 cycle, the only one that loads PC.
                if (wait_q == 4'd0) in_en = in_en | bus_bit(BUS_PC);
                if (mem_ready) begin
                    in_en   = in_en | bus_bit(BUS_MDR);
                    state_d = S_T2;
                end else if (wait_q == 4'd15) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_T2: begin
                busy    = 1'b1;
                bus_sel = bus_bit(BUS_MDR);
                in_en   = bus_bit(BUS_IR);
                state_d = S_T3;
            end
            S_T3: begin
                // Rb is driven even for nop/halt/illegal so the bus stays one-hot while busy.
                busy    = 1'b1;
                bus_sel = {9'd0, rb_oh};
                case (dec_class)
                    CLS_ALU, CLS_MULDIV: begin
                        in_en   = bus_bit(BUS_Y);
                        state_d = S_T4;
                    end
                    CLS_NOP:  state_d = S_T0;
                    CLS_HALT: state_d = S_HALTED;
                    default:  state_d = S_ERROR;
                endcase
            end
            S_T4: begin
                busy    = 1'b1;
                bus_sel = {9'd0, rc_oh};
                alu_op  = dec_alu_op;
                in_en   = bus_bit(BUS_ZLOW) | bus_bit(BUS_ZHIGH);
                state_d = S_T5;
            end
            S_T5: begin
                busy    = 1'b1;
                bus_sel = bus_bit(BUS_ZLOW);
                if (dec_class == CLS_MULDIV) begin
                    in_en   = bus_bit(BUS_LO);
                    state_d = S_T6;
                end else begin
                    in_en   = {9'd0, ra_oh};
                    state_d = S_T0;
                end
            end
            S_T6: begin
                busy    = 1'b1;
                bus_sel = bus_bit(BUS_ZHIGH);
                in_en   = bus_bit(BUS_HI);
                state_d = S_T0;
            end
            S_HALTED: halted  = 1'b1;
            S_ERROR:  illegal = 1'b1;
            default:  state_d = S_ERROR;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and randomized checks of control_sequencer against a cycle-trace model
module tb_control_sequencer;

    localparam int HI = 16, LO = 17, ZH = 18, ZL = 19, PCB = 20, IRB = 21, MDR = 22, MAR = 23, YB = 24;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] ir;
    logic        mem_ready;
    logic [24:0] bus_sel;
    logic [24:0] in_en;
    logic [3:0]  alu_op;
    logic        inc_pc;
    logic        read;
    logic        busy;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    control_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .ir        (ir),
        .mem_ready (mem_ready),
        .bus_sel   (bus_sel),
        .in_en     (in_en),
        .alu_op    (alu_op),
        .inc_pc    (inc_pc),
        .read      (read),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] bus;
        logic [24:0] en;
        logic [8:0]  ctl;
        logic        t1;
        logic        mr;
    } cyc_t;

    cyc_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        assert ($onehot0(bus_sel)) else begin
            errors++;
            $error("FAIL onehot0 observed=%h expected=at-most-one-bit", bus_sel);
        end
    end

    function automatic logic [24:0] b(input int i);
        logic [24:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int alu_code(input logic [4:0] op);
        case (op)
            5'b00011: return 1;
            5'b00100: return 2;
            5'b00101: return 3;
            5'b00110: return 4;
            5'b00111: return 5;
            5'b01000: return 6;
            5'b01001: return 7;
            5'b01010: return 8;
            5'b01111: return 9;
            5'b10000: return 10;
            default:  return 0;
        endcase
    endfunction

    // ctl packs {alu_op, inc_pc, read, busy, halted, illegal}
    task automatic push(input logic [24:0] bus, input logic [24:0] en, input logic [3:0] alu,
                        input logic inc, input logic rd, input logic bsy, input logic hlt,
                        input logic ill, input logic t1, input logic mr);
        cyc_t e;
        e.bus = bus;
        e.en  = en;
        e.ctl = {alu, inc, rd, bsy, hlt, ill};
        e.t1  = t1;
        e.mr  = mr;
        exp_q.push_back(e);
    endtask

    task automatic push_t0();
        push(b(PCB), b(MAR) | b(ZL), 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected per-cycle trace from T0 of one instruction to the next T0 or a terminal state.
    task automatic build(input logic [31:0] instr, input int nwait);
        logic [4:0] op;
        int         code;
        logic       m;
        op   = instr[31:27];
        code = alu_code(op);
        exp_q.delete();
        push_t0();
        for (int k = 0; k < 16; k++) begin
            m = (k == nwait);
            push(b(ZL), (k == 0 ? b(PCB) : 25'd0) | (m ? b(MDR) : 25'd0),
                 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, m);
            if (m) break;
        end
        if (nwait >= 16) begin
            repeat (3) push('0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            return;
        end
        push(b(MDR), b(IRB), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(b(int'(instr[22:19])), (code != 0) ? b(YB) : 25'd0,
             4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (op == 5'b11010) begin
            push_t0();
            return;
        end
        if (op == 5'b11011) begin
            repeat (3) push('0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            return;
        end
        if (code == 0) begin
            repeat (3) push('0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            return;
        end
        push(b(int'(instr[18:15])), b(ZL) | b(ZH), code[3:0], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (code >= 9) begin
            push(b(ZL), b(LO), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            push(b(ZH), b(HI), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            push(b(ZL), b(int'(instr[26:23])), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        push_t0();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".bus"}, {7'd0, bus_sel}, 32'd0);
        chk({tag, ".en"},  {7'd0, in_en},   32'd0);
        chk({tag, ".ctl"}, {23'd0, alu_op, inc_pc, read, busy, halted, illegal}, 32'd0);
    endtask

    // Starts from IDLE, walks the trace, then pulses clr mid-cycle and checks the async clear.
    task automatic run(input string tag, input logic [31:0] instr, input int nwait, input int stop_at);
        ir = instr;
        build(instr, nwait);
        start     = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = exp_q[i].t1 ? exp_q[i].mr : 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("%s[%0d].bus", tag, i), {7'd0, bus_sel}, {7'd0, exp_q[i].bus});
            chk($sformatf("%s[%0d].en", tag, i),  {7'd0, in_en},   {7'd0, exp_q[i].en});
            chk($sformatf("%s[%0d].ctl", tag, i),
                {23'd0, alu_op, inc_pc, read, busy, halted, illegal}, {23'd0, exp_q[i].ctl});
            if (i == exp_q.size() - 1 || i == stop_at) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        clr   = 1'b0;
        #1;
        chk_zero({tag, ".clr"});
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [4:0] legal_ops[12] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                  5'b01001, 5'b01010, 5'b01111, 5'b10000, 5'b11010, 5'b11011};

    initial begin
        logic [4:0]  op;
        logic [31:0] instr;
        int          nw;
        int          r;

        clr       = 1'b0;
        start     = 1'b1;
        mem_ready = 1'b1;
        ir        = 32'h18918000;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        start = 1'b0;
        clr   = 1'b1;
        @(posedge clk); #1;
        chk_zero("idle_nostart");

        run("add_r1_r2_r3", 32'h18918000, 0, -1);
        run("mul_r0_r4_r5", 32'h78228000, 0, -1);
        run("add_wait3",    32'h18918000, 3, -1);
        run("wait15",       32'h20918000, 15, -1);
        run("never_ready",  32'h18918000, 16, -1);
        run("op_11111",     32'hF8918000, 0, -1);
        run("halt",         32'hD8000000, 0, -1);
        run("nop",          32'hD0000000, 1, -1);
        run("div_ra0",      32'h80128000, 2, -1);
        run("clr_mid_t4",   32'h18918000, 0, 4);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80) op = legal_ops[$urandom_range(0, 11)];
            else        op = 5'($urandom_range(0, 31));
            r = int'($urandom_range(0, 9));
            if (r < 6)      nw = int'($urandom_range(0, 3));
            else if (r < 8) nw = int'($urandom_range(4, 15));
            else            nw = 16;
            instr = {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
            run($sformatf("rand%0d", n), instr, nw, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
